// File: rtl/div_arbiter.sv
// Round-robin front end that shares one iterative divider among NREQ requesters.
// One operation is in flight at a time; divide-by-zero and divider timeouts are answered locally.
module div_arbiter #(
  parameter int N       = 4,
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 2*N+4,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int WD_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_dividend,
  input  logic [NREQ*N-1:0] req_divisor,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [ID_W-1:0]   resp_id,
  output logic [N-1:0]      resp_quotient,
  output logic [N-1:0]      resp_remainder,
  output logic              resp_error,
  output logic              div_start,
  output logic [N-1:0]      div_dividend,
  output logic [N-1:0]      div_divisor,
  input  logic [N-1:0]      div_quotient,
  input  logic [N-1:0]      div_remainder,
  input  logic              div_done,
  output logic [2:0]        dbg_state
);

  // Handshakes: a request transfers on an edge where req_valid[i] & req_ready[i];
  // a response transfers on an edge where resp_valid & resp_ready. Neither side may
  // make valid depend on ready; payloads are stable while valid is high and not taken.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N-1:0]      dividend_q, dividend_d;
  logic [N-1:0]      divisor_q, divisor_d;
  logic [N-1:0]      quot_q, quot_d;
  logic [N-1:0]      rem_q, rem_d;
  logic              err_q, err_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WD_W-1:0]   wd_inc;
  logic [ID_W:0]     pick;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;

  // Returns {found, index}; the search begins just after the previous winner.
  function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] valid,
                                            input logic [ID_W-1:0] last);
    logic [ID_W:0] cand;
    logic [ID_W:0] res;
    logic          found;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NREQ)) cand = cand - (ID_W+1)'(NREQ);
      if (!found && valid[cand[ID_W-1:0]]) begin
        found = 1'b1;
        res   = {1'b1, cand[ID_W-1:0]};
      end
    end
    return res;
  endfunction

  assign pick        = rr_pick(req_valid, last_grant_q);
  assign grant_found = pick[ID_W];
  assign grant_idx   = pick[ID_W-1:0];
  assign wd_inc      = wd_q + WD_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NREQ-1);
      id_q         <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
      wd_q         <= wd_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    err_d        = err_q;
    wd_d         = wd_q;
    case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (grant_found) begin
          state_d      = S_ISSUE;
          last_grant_d = grant_idx;
          id_d         = grant_idx;
          dividend_d   = req_dividend[grant_idx*N +: N];
          divisor_d    = req_divisor[grant_idx*N +: N];
        end
      end
      S_ISSUE: begin
        wd_d = '0;
        if (divisor_q == '0) begin
          quot_d  = '1;
          rem_d   = dividend_q;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_SETTLE;
        end
      end
      // The divider's done from the previous operation is still visible here.
      S_SETTLE: begin
        wd_d    = wd_inc;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          quot_d  = div_quotient;
          rem_d   = div_remainder;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_inc >= WD_W'(TIMEOUT)) begin
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (!reset && state_q == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
    div_start  = (state_q == S_ISSUE) && (divisor_q != '0);
    resp_valid = (state_q == S_RESP);
  end

  assign resp_id        = id_q;
  assign resp_quotient  = quot_q;
  assign resp_remainder = rem_q;
  assign resp_error     = err_q;
  assign div_dividend   = dividend_q;
  assign div_divisor    = divisor_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider, reference arbiter/divide model,
// scoreboard queue popped by a response monitor, directed scenarios then random traffic.
module tb_div_arbiter;

  localparam int N       = 4;
  localparam int NREQ    = 3;
  localparam int TIMEOUT = 2*N+4;
  localparam int ID_W    = $clog2(NREQ);
  localparam int E_W     = ID_W + 2*N + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*N-1:0] req_dividend, req_divisor;
  logic              resp_valid, resp_ready, resp_error;
  logic [ID_W-1:0]   resp_id;
  logic [N-1:0]      resp_quotient, resp_remainder;
  logic              div_start;
  logic [N-1:0]      div_dividend, div_divisor;
  logic [N-1:0]      div_quotient = '0;
  logic [N-1:0]      div_remainder = '0;
  logic              div_done = 1'b0;
  logic [2:0]        dbg_state;

  logic [N-1:0] dvd [NREQ];
  logic [N-1:0] dvs [NREQ];
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*N +: N] = dvd[i];
      req_divisor[i*N +: N]  = dvs[i];
    end
  end

  div_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_quotient(resp_quotient),
    .resp_remainder(resp_remainder), .resp_error(resp_error),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .dbg_state(dbg_state)
  );

  // ---------------- behavioural divider ----------------
  // done stays high until one cycle after the next start, then rises after div_lat more cycles.
  bit stub_mode = 1'b0;
  int div_lat = 2;
  logic [N-1:0] da, db;
  int dcnt = 0;
  int dst = 0;
  always @(posedge clk) begin
    if (div_start) begin
      da <= div_dividend; db <= div_divisor; dcnt <= div_lat; dst <= 1;
    end else if (dst == 1) begin
      div_done <= 1'b0; dst <= 2;
    end else if (dst == 2) begin
      if (dcnt == 0) begin
        if (!stub_mode) begin
          div_done      <= 1'b1;
          div_quotient  <= (db != 0) ? da / db : '1;
          div_remainder <= (db != 0) ? da % db : da;
        end
        dst <= 0;
      end else begin
        dcnt <= dcnt - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_pass = 0;
  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  function automatic logic [E_W-1:0] pk(int id, int q, int r, bit e);
    return {ID_W'(id), N'(q), N'(r), e};
  endfunction

  // Reference: zero divisor -> all-ones/dividend/error; timeout -> 0/0/error; else plain arithmetic.
  function automatic logic [E_W-1:0] model_resp(int id, logic [N-1:0] a, logic [N-1:0] b, bit timed_out);
    if (b == 0) return pk(id, (1 << N) - 1, int'(a), 1'b1);
    if (timed_out) return pk(id, 0, 0, 1'b1);
    return pk(id, int'(a / b), int'(a % b), 1'b0);
  endfunction

  function automatic int rr_winner(logic [NREQ-1:0] v, int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] resp_log[$];
  int grant_log[$];
  int model_last = NREQ-1;
  bit busy = 1'b0;
  bit stall_prev = 1'b0;
  bit hs_prev = 1'b0;
  bit start_due = 1'b0;
  logic [E_W-1:0] held;
  int accept_cyc = 0, start_cyc = 0, resp_start_cyc = 0;

  always @(negedge clk) begin
    logic [E_W-1:0] resp_now;
    logic [NREQ-1:0] acc_m, exp_rdy;
    int w, idx;
    if (rst) begin
      model_last = NREQ-1; busy = 0; stall_prev = 0; hs_prev = 0; start_due = 0;
    end else begin
      if (div_start || start_due) chk("div_start", div_start, start_due);
      if (div_start) start_cyc = cyc;
      start_due = 1'b0;

      if (busy) begin
        if (|req_valid || |req_ready) chk("req_ready_busy", req_ready, 0);
      end else if (|req_valid) begin
        w = rr_winner(req_valid, model_last);
        exp_rdy = '0;
        exp_rdy[w] = 1'b1;
        chk("grant", req_ready, exp_rdy);
      end else if (|req_ready) begin
        chk("req_ready_no_valid", req_ready, 0);
      end

      acc_m = req_valid & req_ready;
      if (|acc_m) begin
        idx = 0;
        for (int i = NREQ-1; i >= 0; i--) if (acc_m[i]) idx = i;
        exp_q.push_back(model_resp(idx, dvd[idx], dvs[idx], stub_mode));
        grant_log.push_back(idx);
        model_last = idx;
        busy = 1'b1;
        start_due = (dvs[idx] != 0);
        accept_cyc = cyc;
      end

      resp_now = {resp_id, resp_quotient, resp_remainder, resp_error};
      if (hs_prev) chk("resp_valid_one_cycle", resp_valid, 0);
      if (stall_prev) begin
        chk("resp_hold_valid", resp_valid, 1);
        chk("resp_hold_fields", resp_now, held);
      end
      if (resp_valid && !stall_prev) resp_start_cyc = cyc;
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL resp_unexpected: got %0h expected none (cycle %0d)", resp_now, cyc);
        end else begin
          chk("resp", resp_now, exp_q.pop_front());
        end
        resp_log.push_back(resp_now);
        busy = 1'b0;
      end
      hs_prev    = resp_valid && resp_ready;
      stall_prev = resp_valid && !resp_ready;
      held       = resp_now;
    end
  end

  // ---------------- driver tasks ----------------
  int mode = 0;  // 0: drop after accept, 1: hold valid, 2: random traffic
  logic [NREQ-1:0] acc;
  bit s_rv, s_start;

  task automatic cycle();
    @(negedge clk);
    acc = req_valid & req_ready;
    s_rv = resp_valid;
    s_start = div_start;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        if (mode == 0) begin
          req_valid[i] = 1'b0;
          dvd[i] = N'($urandom);
          dvs[i] = N'($urandom);
        end else if (mode == 2) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          dvd[i] = N'($urandom);
          dvs[i] = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
        end
      end else if (mode == 2 && !req_valid[i] && $urandom_range(0, 2) == 0) begin
        req_valid[i] = 1'b1;
        dvd[i] = N'($urandom);
        dvs[i] = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
      end
    end
    if (mode == 2) begin
      resp_ready = ($urandom_range(0, 2) != 0);
      div_lat = $urandom_range(0, N);
    end
  endtask

  task automatic wait_accept(string name);
    int t = 0;
    do begin
      cycle();
      t++;
    end while (acc == 0 && t < 50);
    chk({name, "_accept"}, |acc, 1);
  endtask

  task automatic wait_idle(string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin
      cycle();
      t++;
    end
    chk({name, "_drain"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, "_req_ready"}, req_ready, 0);
    chk({name, "_resp_valid"}, resp_valid, 0);
    chk({name, "_resp_id"}, resp_id, 0);
    chk({name, "_resp_q"}, resp_quotient, 0);
    chk({name, "_resp_r"}, resp_remainder, 0);
    chk({name, "_resp_err"}, resp_error, 0);
    chk({name, "_div_start"}, div_start, 0);
    chk({name, "_div_dividend"}, div_dividend, 0);
    chk({name, "_div_divisor"}, div_divisor, 0);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete(); grant_log.delete(); resp_log.delete();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    resp_ready = 1'b1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin dvd[i] = 4'd5; dvs[i] = 4'd3; end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");

    // Single request, presented in the first cycle after reset release.
    req_valid = '0;
    dvd[0] = 4'd13; dvs[0] = 4'd3;
    req_valid[0] = 1'b1;
    mode = 0;
    rst = 1'b0;
    wait_accept("single");
    chk("single_first_cycle", accept_cyc, 3);
    wait_idle("single");
    chk("single_resp", resp_log.size() > 0 ? resp_log[0] : '0, pk(0, 4, 1, 0));

    // Contention from reset: all three held valid.
    reset_dut();
    dvd[0] = 4'd15; dvs[0] = 4'd2;
    dvd[1] = 4'd9;  dvs[1] = 4'd4;
    dvd[2] = 4'd7;  dvs[2] = 4'd7;
    req_valid = '1;
    mode = 1;
    for (int t = 0; t < 100 && grant_log.size() < 4; t++) cycle();
    req_valid = '0;
    wait_idle("contention");
    chk("cont_ngrant", grant_log.size(), 4);
    if (grant_log.size() >= 4 && resp_log.size() >= 4) begin
      chk("cont_g0", grant_log[0], 0);
      chk("cont_g1", grant_log[1], 1);
      chk("cont_g2", grant_log[2], 2);
      chk("cont_g3", grant_log[3], 0);
      chk("cont_r0", resp_log[0], pk(0, 7, 1, 0));
      chk("cont_r1", resp_log[1], pk(1, 2, 1, 0));
      chk("cont_r2", resp_log[2], pk(2, 1, 0, 0));
      chk("cont_r3", resp_log[3], pk(0, 7, 1, 0));
    end

    // Divide by zero.
    resp_log.delete();
    mode = 0;
    dvd[1] = 4'd9; dvs[1] = 4'd0;
    req_valid[1] = 1'b1;
    wait_accept("div0");
    wait_idle("div0");
    chk("div0_latency_le3", (resp_start_cyc - accept_cyc) inside {[1:3]}, 1);
    chk("div0_resp", resp_log.size() > 0 ? resp_log[0] : '0, pk(1, 15, 9, 1));

    // Backpressure: hold resp_ready low for ten cycles with other requests pending.
    resp_log.delete();
    resp_ready = 1'b0;
    dvd[0] = 4'd11; dvs[0] = 4'd3;
    req_valid[0] = 1'b1;
    wait_accept("bp");
    dvd[1] = 4'd14; dvs[1] = 4'd5;
    dvd[2] = 4'd8;  dvs[2] = 4'd3;
    req_valid[1] = 1'b1; req_valid[2] = 1'b1;
    for (int t = 0; t < 20 && !s_rv; t++) cycle();
    chk("bp_resp_valid", s_rv, 1);
    repeat (10) begin
      cycle();
      chk("bp_no_accept", acc, 0);
    end
    resp_ready = 1'b1;
    cycle();
    chk("bp_no_accept_on_hs", acc, 0);
    cycle();
    chk("bp_accept_next", acc, 3'b010);
    req_valid = '0;
    wait_idle("bp");
    if (resp_log.size() >= 2) begin
      chk("bp_r0", resp_log[0], pk(0, 3, 2, 0));
      chk("bp_r1", resp_log[1], pk(1, 2, 4, 0));
    end else begin
      chk("bp_nresp", resp_log.size(), 2);
    end

    // Timeout with the divider's done stuck low.
    resp_log.delete();
    stub_mode = 1'b1;
    dvd[0] = 4'd5; dvs[0] = 4'd2;
    req_valid[0] = 1'b1;
    wait_accept("timeout");
    wait_idle("timeout");
    stub_mode = 1'b0;
    chk("timeout_latency", resp_start_cyc - start_cyc, TIMEOUT + 1);
    chk("timeout_resp", resp_log.size() > 0 ? resp_log[0] : '0, pk(0, 0, 0, 1));

    // Reset while waiting on the divider.
    div_lat = N;
    dvd[2] = 4'd12; dvs[2] = 4'd5;
    req_valid[2] = 1'b1;
    s_start = 1'b0;
    for (int t = 0; t < 20 && !s_start; t++) cycle();
    chk("rstwait_started", s_start, 1);
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    check_reset_outputs("rstwait");
    exp_q.delete(); grant_log.delete(); resp_log.delete();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) begin
      cycle();
      chk("rstwait_no_resp", s_rv, 0);
    end
    dvd[0] = 4'd6; dvs[0] = 4'd3;
    req_valid[0] = 1'b1;
    wait_accept("rstwait");
    wait_idle("rstwait");
    chk("rstwait_resp", resp_log.size() > 0 ? resp_log[0] : '0, pk(0, 2, 0, 0));

    // Random traffic.
    mode = 2;
    repeat (400) cycle();
    mode = 0;
    req_valid = '0;
    resp_ready = 1'b1;
    div_lat = 2;
    wait_idle("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
